// File: rtl/riscv_imm_pkg.sv
// riscv_imm_pkg: immediate-type and encoder error codes shared by the decode and encode paths
package riscv_imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_TYPE  = 2'b11;

    // True when v[31:lo] are all equal, i.e. v survives sign extension from bit lo
    function automatic logic sext_ok(input logic [31:0] v, input int unsigned lo);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << lo;
        return ((v & m) == 32'h0) || ((v & m) == m);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// imm_pack: packs a 32-bit immediate into instr[31:7] for the given type and flags unrepresentable values
module imm_pack
    import riscv_imm_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm_val,
    output logic [24:0] field,
    output logic [1:0]  err_code
);

    logic [24:0] w_f_i, w_f_s, w_f_b, w_f_u, w_f_j;
    logic        w_ok12, w_ok13, w_ok21, w_odd, w_lo_nz;

    assign w_f_i = {imm_val[11:0], 13'b0};
    assign w_f_s = {imm_val[11:5], 13'b0, imm_val[4:0]};
    assign w_f_b = {imm_val[12], imm_val[10:5], 13'b0, imm_val[4:1], imm_val[11]};
    assign w_f_u = {imm_val[31:12], 5'b0};
    assign w_f_j = {imm_val[20], imm_val[10:1], imm_val[11], imm_val[19:12], 5'b0};

    assign w_ok12  = sext_ok(imm_val, 11);
    assign w_ok13  = sext_ok(imm_val, 12);
    assign w_ok21  = sext_ok(imm_val, 20);
    assign w_odd   = imm_val[0];
    assign w_lo_nz = |imm_val[11:0];

    always_comb begin
        field    = (imm_src == IMM_I) ? w_f_i :
                   (imm_src == IMM_S) ? w_f_s :
                   (imm_src == IMM_B) ? w_f_b :
                   (imm_src == IMM_U) ? w_f_u :
                   (imm_src == IMM_J) ? w_f_j : 25'h0;
        // Misalignment outranks range; U only has the low-zero requirement
        err_code = (imm_src == IMM_I || imm_src == IMM_S) ? (w_ok12 ? ERR_OK : ERR_RANGE) :
                   (imm_src == IMM_B) ? (w_odd ? ERR_ALIGN : w_ok13 ? ERR_OK : ERR_RANGE) :
                   (imm_src == IMM_U) ? (w_lo_nz ? ERR_ALIGN : ERR_OK) :
                   (imm_src == IMM_J) ? (w_odd ? ERR_ALIGN : w_ok21 ? ERR_OK : ERR_RANGE) :
                   ERR_TYPE;
    end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: two-stage valid/ready immediate encoder with saturating handoff statistics
module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_src,
    input  logic [31:0]      imm_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [24:0]      imm_field,
    output logic             err,
    output logic [1:0]       err_code,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    logic             r_s1_valid, r_s2_valid;
    logic [2:0]       r_s1_src;
    logic [31:0]      r_s1_val;
    logic [24:0]      r_s2_field;
    logic [1:0]       r_s2_code;
    logic [CNT_W-1:0] r_enc, r_err;
    logic [24:0]      w_field;
    logic [1:0]       w_code;
    logic             w_s2_adv, w_s1_adv, w_out_xfer;

    assign w_s2_adv   = !r_s2_valid || out_ready;
    assign w_s1_adv   = w_s2_adv || !r_s1_valid;
    assign w_out_xfer = r_s2_valid && out_ready;

    imm_pack u_pack (
        .imm_src  (r_s1_src),
        .imm_val  (r_s1_val),
        .field    (w_field),
        .err_code (w_code)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_src   <= 3'b0;
            r_s1_val   <= 32'h0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_src <= imm_src;
                r_s1_val <= imm_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_field <= 25'h0;
            r_s2_code  <= ERR_OK;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_field <= w_field;
                r_s2_code  <= w_code;
            end
        end
    end

    // Clear wins over a same-cycle handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enc <= '0;
            r_err <= '0;
        end else if (stats_clr) begin
            r_enc <= '0;
            r_err <= '0;
        end else if (w_out_xfer) begin
            r_enc <= (&r_enc) ? r_enc : r_enc + CNT_W'(1);
            r_err <= (r_s2_code == ERR_OK || &r_err) ? r_err : r_err + CNT_W'(1);
        end
    end

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign imm_field = r_s2_field;
    assign err_code  = r_s2_code;
    assign err       = r_s2_code != ERR_OK;
    assign enc_count = r_enc;
    assign err_count = r_err;

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: scoreboard bench for imm_encoder against a range/alignment and decode-extender model
module tb_imm_encoder;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0, stats_clr = 1'b0;
    logic          in_ready, out_valid, err;
    logic [2:0]    imm_src = 3'b0;
    logic [31:0]   imm_val = 32'h0;
    logic [24:0]   imm_field;
    logic [1:0]    err_code;
    logic [CW-1:0] enc_count, err_count;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] val;
        bit          hasf;
        logic [24:0] f;
    } req_t;

    req_t          sb[$];
    bit            drv_hasf = 1'b0;
    logic [24:0]   drv_f = 25'h0;
    bit            rand_ready = 1'b0;
    int            checks = 0, errors = 0, n_xfer = 0;
    logic [CW-1:0] m_enc = '0, m_err = '0;
    bit            prev_hold = 1'b0;
    logic [24:0]   prev_f = 25'h0;
    logic [1:0]    prev_c = 2'b0;

    imm_encoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_src   (imm_src),
        .imm_val   (imm_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .imm_field (imm_field),
        .err       (err),
        .err_code  (err_code),
        .stats_clr (stats_clr),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Decode-stage extender: field is instr[31:7]
    function automatic logic [31:0] decode(input logic [2:0] s, input logic [24:0] f);
        case (s)
            3'd0:    return {{20{f[24]}}, f[24:13]};
            3'd1:    return {{20{f[24]}}, f[24:18], f[4:0]};
            3'd2:    return {{19{f[24]}}, f[24], f[0], f[23:18], f[4:1], 1'b0};
            3'd3:    return {f[24:5], 12'b0};
            3'd4:    return {{11{f[24]}}, f[24], f[12:5], f[13], f[23:14], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [1:0] exp_code(input logic [2:0] s, input logic [31:0] v);
        longint x;
        x = $signed(v);
        case (s)
            3'd0, 3'd1: return (x < -2048 || x > 2047) ? 2'd1 : 2'd0;
            3'd2:       return (v % 2 != 0) ? 2'd2 : (x < -4096 || x > 4095) ? 2'd1 : 2'd0;
            3'd3:       return (v % 4096 != 0) ? 2'd2 : 2'd0;
            3'd4:       return (v % 2 != 0) ? 2'd2 : (x < -(1 << 20) || x >= (1 << 20)) ? 2'd1 : 2'd0;
            default:    return 2'd3;
        endcase
    endfunction

    // Value the field should decode back to: the immediate truncated to its encodable bits
    function automatic logic [31:0] exp_trunc(input logic [2:0] s, input logic [31:0] v);
        longint t;
        case (s)
            3'd0, 3'd1: begin t = v % 4096; if (t >= 2048) t -= 4096; end
            3'd2:       begin t = (v % 8192) & ~longint'(1); if (t >= 4096) t -= 8192; end
            3'd3:       t = v - v % 4096;
            3'd4:       begin t = (v % (1 << 21)) & ~longint'(1); if (t >= (1 << 20)) t -= (1 << 21); end
            default:    t = 0;
        endcase
        return 32'(t);
    endfunction

    function automatic logic [24:0] unused_mask(input logic [2:0] s);
        case (s)
            3'd0:       return 25'h0001FFF;
            3'd1, 3'd2: return 25'h003FFE0;
            3'd3, 3'd4: return 25'h000001F;
            default:    return 25'h1FFFFFF;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_enc = '0;
            m_err = '0;
            prev_hold = 1'b0;
        end else begin
            bit xfer;
            req_t r;
            logic [1:0] ec;
            chk("enc_count", 32'(enc_count), 32'(m_enc));
            chk("err_count", 32'(err_count), 32'(m_err));
            if (prev_hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_field", 32'(imm_field), 32'(prev_f));
                chk("hold_code", 32'(err_code), 32'(prev_c));
            end
            xfer = out_valid && out_ready;
            if (xfer) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(imm_field), 32'h0BADBAD);
                end else begin
                    r  = sb.pop_front();
                    ec = exp_code(r.src, r.val);
                    chk("err_code", 32'(err_code), 32'(ec));
                    chk("err", 32'(err), 32'(ec != 2'd0));
                    chk("field_unused", 32'(imm_field & unused_mask(r.src)), 32'h0);
                    chk("field_decode", decode(r.src, imm_field), exp_trunc(r.src, r.val));
                    if (ec == 2'd0) chk("round_trip", decode(r.src, imm_field), r.val);
                    if (r.hasf) chk("field_exact", 32'(imm_field), 32'(r.f));
                    if (!stats_clr && err && m_err != CMAX) m_err = m_err + 1'b1;
                end
                if (!stats_clr && m_enc != CMAX) m_enc = m_enc + 1'b1;
            end
            if (stats_clr) begin
                m_enc = '0;
                m_err = '0;
            end
            prev_hold = out_valid && !out_ready;
            prev_f    = imm_field;
            prev_c    = err_code;
            if (in_valid && in_ready) sb.push_back('{imm_src, imm_val, drv_hasf, drv_f});
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) begin
            out_ready = $urandom_range(0, 3) != 0;
            stats_clr = $urandom_range(0, 499) == 0;
        end
    end

    task automatic send(input logic [2:0] s, input logic [31:0] v,
                        input bit hf = 1'b0, input logic [24:0] f = 25'h0);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        imm_src  = s;
        imm_val  = v;
        drv_hasf = hf;
        drv_f    = f;
        in_valid = 1'b1;
        while (!acc && n < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        if (!rand_ready) out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        int k, x0;
        logic [24:0] hf;
        logic [2:0] s;
        logic [31:0] v;
        int unsigned w;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_field", 32'(imm_field), 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_enc", 32'(enc_count), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        send(3'd0, 32'hFFFFFFFF, 1'b1, 25'h1FFE000);
        chk("lat_n1", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_n2", 32'(out_valid), 32'd1);
        drain();
        chk("enc_first", 32'(enc_count), 32'd1);

        send(3'd2, 32'hFFFFF000, 1'b1, 25'h1000000);
        send(3'd2, 32'h00000003);
        send(3'd3, 32'h12345000, 1'b1, 25'h02468A0);
        send(3'd4, 32'h00000800, 1'b1, 25'h0002000);
        send(3'd0, 32'd2048);
        send(3'd6, 32'h00000123, 1'b1, 25'h0);
        drain();
        chk("enc_directed", 32'(enc_count), 32'd7);
        chk("err_directed", 32'(err_count), 32'd3);

        out_ready = 1'b0;
        k = 0;
        x0 = n_xfer;
        hf = 25'h0;
        for (int c = 0; c < 9; c++) begin
            if (k < 4) begin
                imm_src  = 3'd0;
                imm_val  = 32'(100 * (k + 1));
                drv_hasf = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (c == 5) out_ready = 1'b1;
            @(negedge clk);
            if (c == 2) begin
                hf = imm_field;
                chk("bp_out_valid", 32'(out_valid), 32'd1);
            end
            if (c == 4) begin
                chk("bp_accepted", 32'(k), 32'd2);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_hold", 32'(imm_field), 32'(hf));
            end
            if (in_valid && in_ready) k++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_xfers", 32'(n_xfer - x0), 32'd4);
        drain();

        for (int i = 0; i < 20; i++) send(3'd1, 32'(i));
        drain();
        chk("sat_enc", 32'(enc_count), 32'd15);
        out_ready = 1'b0;
        send(3'd0, 32'd5);
        @(posedge clk);
        #1;
        stats_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        chk("clr_enc", 32'(enc_count), 32'd0);
        chk("clr_err", 32'(err_count), 32'd0);

        send(3'd0, 32'd9);
        drain();
        out_ready = 1'b0;
        send(3'd0, 32'd7);
        send(3'd1, 32'd8);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_field", 32'(imm_field), 32'h0);
        chk("mid_rst_enc", 32'(enc_count), 32'd0);
        chk("mid_rst_err", 32'(err_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            w = $urandom_range(1, 32);
            v = $urandom;
            if (w < 32) v = 32'($signed(v << (32 - w)) >>> (32 - w));
            case ($urandom_range(0, 3))
                0:       v[0] = 1'b0;
                1:       v[11:0] = 12'h0;
                default: ;
            endcase
            send(s, v);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
